// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: reset/lock sequencer for the system PLL.
// Purpose: holds the PLL in reset, then synchronizes and qualifies its lock
// output. Downstream reset is released only after lock has been stable for
// LOCK_STABLE cycles. A lock timeout retries the PLL reset up to RETRY_MAX
// extra times before giving up. Loss of lock while running re-sequences.
// Ports:
//   i_clk          reference clock (single domain)
//   i_reset_n      asynchronous active-low reset
//   i_pll_locked   raw PLL lock, asynchronous to i_clk
//   i_restart_req  single-cycle request to restart the sequence
//   o_pll_rst      active-high PLL reset
//   o_sys_reset_n  active-low downstream reset (high only in RUN)
//   o_lock_lost    sticky: lock dropped while in RUN
//   o_fail         sticky: retries exhausted
//   o_retry_cnt    retries used in the current sequence
//   o_state        status: 1 PLL_RST, 2 WAIT_LOCK, 3 STABLE, 4 RUN, 5 FAIL
module pll_lock_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 1024,
    parameter int RETRY_MAX    = 3,
    parameter int CNT_W        = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_pll_locked,
    input  logic       i_restart_req,
    output logic       o_pll_rst,
    output logic       o_sys_reset_n,
    output logic       o_lock_lost,
    output logic       o_fail,
    output logic [1:0] o_retry_cnt,
    output logic [2:0] o_state
);
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [1:0]       RETRY_LIM = 2'(RETRY_MAX);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sync;
    logic [1:0]       r_retry;
    logic             r_pll_rst;
    logic             r_sys_reset_n;
    logic             r_lock_lost;
    logic             r_fail;
    logic             w_locked_s;

    assign w_locked_s = r_sync[1];

    // Two-flop synchronizer; the raw lock input is used nowhere else.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_sync <= 2'b00;
        else
            r_sync <= {r_sync[0], i_pll_locked};
    end

    // Every state entry clears r_cnt; outputs are set alongside the next
    // state so they change on the same edge as r_state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_PLL_RST;
            r_cnt         <= '0;
            r_retry       <= 2'd0;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_fail        <= 1'b0;
        end else if (i_restart_req) begin
            // Restart overrides any timeout or lock-drop decision this cycle.
            r_state       <= ST_PLL_RST;
            r_cnt         <= '0;
            r_retry       <= 2'd0;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            r_lock_lost   <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            case (r_state)
                ST_PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state   <= ST_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        if (r_retry < RETRY_LIM) begin
                            r_retry <= r_retry + 2'd1;
                            r_state <= ST_PLL_RST;
                        end else begin
                            r_fail  <= 1'b1;
                            r_state <= ST_FAIL;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    // A drop restarts the wait with a fresh timeout; not a retry.
                    if (!w_locked_s) begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == ST_LAST) begin
                        r_state       <= ST_RUN;
                        r_cnt         <= '0;
                        r_retry       <= 2'd0;
                        r_sys_reset_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        r_state       <= ST_PLL_RST;
                        r_cnt         <= '0;
                        r_retry       <= 2'd0;
                        r_lock_lost   <= 1'b1;
                        r_pll_rst     <= 1'b1;
                        r_sys_reset_n <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    r_pll_rst     <= 1'b1;
                    r_sys_reset_n <= 1'b0;
                end
                default: begin
                    // Unused encodings recover through a fresh PLL reset.
                    r_state       <= ST_PLL_RST;
                    r_cnt         <= '0;
                    r_pll_rst     <= 1'b1;
                    r_sys_reset_n <= 1'b0;
                end
            endcase
        end
    end

    assign o_pll_rst     = r_pll_rst;
    assign o_sys_reset_n = r_sys_reset_n;
    assign o_lock_lost   = r_lock_lost;
    assign o_fail        = r_fail;
    assign o_retry_cnt   = r_retry;
    assign o_state       = r_state;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: self-checking bench for pll_lock_sequencer.
// Ports: none (top-level bench); drives the DUT with RESET_CYCLES=4,
// LOCK_TIMEOUT=32, LOCK_STABLE=8, RETRY_MAX=2.
module tb_pll_lock_sequencer;
    localparam int RC = 4;
    localparam int TO = 32;
    localparam int SL = 8;
    localparam int RM = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart_req = 1'b0;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       lock_lost;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES(RC),
        .LOCK_TIMEOUT(TO),
        .LOCK_STABLE (SL),
        .RETRY_MAX   (RM),
        .CNT_W       (16)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_pll_locked (pll_locked),
        .i_restart_req(restart_req),
        .o_pll_rst    (pll_rst),
        .o_sys_reset_n(sys_reset_n),
        .o_lock_lost  (lock_lost),
        .o_fail       (fail),
        .o_retry_cnt  (retry_cnt),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    // Reference model: time-based. Each phase remembers the edge at which it
    // was entered and leaves once the elapsed edge count reaches the phase
    // length. The synchronizer is a two-deep history of sampled lock values.
    int m_n = 0;
    int m_t0 = 0;
    int m_st = 1;
    int m_retry = 0;
    bit m_fail = 0;
    bit m_lost = 0;
    bit m_hist[$] = '{0, 0};

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_n = 0; m_t0 = 0; m_st = 1; m_retry = 0; m_fail = 0; m_lost = 0;
            m_hist = '{0, 0};
        end else begin
            bit ls;
            int el;
            ls = m_hist.pop_front();
            m_hist.push_back(pll_locked);
            m_n++;
            el = m_n - m_t0;
            if (restart_req) begin
                m_st = 1; m_t0 = m_n; m_retry = 0; m_fail = 0; m_lost = 0;
            end else if (m_st == 1) begin
                if (el == RC) begin m_st = 2; m_t0 = m_n; end
            end else if (m_st == 2) begin
                if (ls) begin
                    m_st = 3; m_t0 = m_n;
                end else if (el == TO) begin
                    m_t0 = m_n;
                    if (m_retry < RM) begin m_retry++; m_st = 1; end
                    else begin m_fail = 1; m_st = 5; end
                end
            end else if (m_st == 3) begin
                if (!ls) begin m_st = 2; m_t0 = m_n; end
                else if (el == SL) begin m_st = 4; m_t0 = m_n; m_retry = 0; end
            end else if (m_st == 4) begin
                if (!ls) begin m_st = 1; m_t0 = m_n; m_retry = 0; m_lost = 1; end
            end
        end
    end

    typedef struct {
        int         n;
        bit         lk;
        bit         rq;
        logic [2:0] st;
        bit         prst;
        bit         sysn;
        bit         lost;
        bit         fl;
        logic [1:0] rc;
    } vec_t;

    vec_t tbl [17];

    function automatic logic [8:0] got_vec();
        return {state, pll_rst, sys_reset_n, lock_lost, fail, retry_cnt};
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_model();
        logic [8:0] e;
        e = {3'(m_st), (m_st == 1 || m_st == 5), (m_st == 4), m_lost, m_fail, 2'(m_retry)};
        chk("model", int'(got_vec()), int'(e));
    endtask

    task automatic step(input bit lk, input bit rq);
        pll_locked = lk;
        restart_req = rq;
        @(posedge clk);
        @(negedge clk);
        restart_req = 1'b0;
        chk_model();
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++)
            for (int k = 0; k < tbl[r].n; k++) begin
                step(tbl[r].lk, tbl[r].rq);
                chk($sformatf("row%0d", r), int'(got_vec()),
                    int'({tbl[r].st, tbl[r].prst, tbl[r].sysn, tbl[r].lost, tbl[r].fl, tbl[r].rc}));
            end
    endtask

    task automatic do_reset();
        pll_locked = 1'b0;
        restart_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hi_cnt, rise_cnt, wait_cnt;
        bit prev;
        int rises[$];
        bit lk;
        int rate;
        // bring-up, loss of lock in RUN, relock with lock_lost sticky
        tbl[0]  = '{3,  0, 0, 3'd1, 1, 0, 0, 0, 2'd0};
        tbl[1]  = '{10, 0, 0, 3'd2, 0, 0, 0, 0, 2'd0};
        tbl[2]  = '{2,  1, 0, 3'd2, 0, 0, 0, 0, 2'd0};
        tbl[3]  = '{8,  1, 0, 3'd3, 0, 0, 0, 0, 2'd0};
        tbl[4]  = '{3,  1, 0, 3'd4, 0, 1, 0, 0, 2'd0};
        tbl[5]  = '{2,  0, 0, 3'd4, 0, 1, 0, 0, 2'd0};
        tbl[6]  = '{4,  0, 0, 3'd1, 1, 0, 1, 0, 2'd0};
        tbl[7]  = '{2,  1, 0, 3'd2, 0, 0, 1, 0, 2'd0};
        tbl[8]  = '{8,  1, 0, 3'd3, 0, 0, 1, 0, 2'd0};
        tbl[9]  = '{3,  1, 0, 3'd4, 0, 1, 1, 0, 2'd0};
        // restart from RUN, relock with lock already present, then restart
        // colliding with a lock drop in RUN
        tbl[10] = '{1,  1, 1, 3'd1, 1, 0, 0, 0, 2'd0};
        tbl[11] = '{3,  1, 0, 3'd1, 1, 0, 0, 0, 2'd0};
        tbl[12] = '{1,  1, 0, 3'd2, 0, 0, 0, 0, 2'd0};
        tbl[13] = '{8,  1, 0, 3'd3, 0, 0, 0, 0, 2'd0};
        tbl[14] = '{2,  1, 0, 3'd4, 0, 1, 0, 0, 2'd0};
        tbl[15] = '{2,  0, 0, 3'd4, 0, 1, 0, 0, 2'd0};
        tbl[16] = '{1,  0, 1, 3'd1, 1, 0, 0, 0, 2'd0};

        repeat (3) @(negedge clk);
        chk("reset_state", int'(got_vec()), int'({3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}));
        chk_model();
        reset_n = 1'b1;
        run_rows(0, 9);

        // asynchronous reset between edges while in RUN with lock_lost set
        #2 reset_n = 1'b0;
        #1 chk("async_reset", int'(got_vec()), int'({3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}));
        @(negedge clk);
        reset_n = 1'b1;

        // STABLE glitch: lock sampled at e0=edge 6, low at e5/e6, back at e7
        for (int e = 1; e <= 23; e++) begin
            step(e >= 6 && e != 11 && e != 12, 0);
            if (e == 13) chk("glitch_wait", int'({state, sys_reset_n}), int'({3'd2, 1'b0}));
            if (e == 22) chk("glitch_stable", int'({state, sys_reset_n}), int'({3'd3, 1'b0}));
            if (e == 23) chk("glitch_run", int'({state, sys_reset_n}), int'({3'd4, 1'b1}));
        end
        run_rows(10, 16);

        // lock never arrives: three attempts, then FAIL
        do_reset();
        hi_cnt = int'(pll_rst);
        prev = pll_rst;
        rise_cnt = 0;
        wait_cnt = 0;
        for (int e = 1; e <= 107; e++) begin
            step(0, 0);
            hi_cnt += int'(pll_rst);
            wait_cnt += int'(state == 3'd2);
            if (pll_rst && !prev) rises.push_back(int'(retry_cnt));
            prev = pll_rst;
        end
        chk("pll_rst_high_cycles", hi_cnt, 3 * RC);
        chk("wait_cycles", wait_cnt, 3 * TO);
        chk("retry_pulses", rises.size(), 2);
        if (rises.size() == 2) begin
            chk("retry_first", rises[0], 1);
            chk("retry_second", rises[1], 2);
        end
        step(0, 0);
        chk("fail_entry", int'(got_vec()), int'({3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2}));
        repeat (5) step(0, 0);
        chk("fail_hold", int'(got_vec()), int'({3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2}));
        step(0, 1);
        chk("restart_in_fail", int'(got_vec()), int'({3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}));

        // restart on the final timeout edge: no FAIL, counters cleared
        repeat (107) step(0, 0);
        chk("before_last_timeout", int'({state, retry_cnt}), int'({3'd2, 2'd2}));
        step(0, 1);
        chk("restart_on_timeout", int'(got_vec()), int'({3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}));
        step(0, 0);
        chk("after_restart", int'({state, fail}), int'({3'd1, 1'b0}));

        // randomized lock behaviour with occasional restarts
        lk = 0;
        for (int b = 0; b < 15; b++) begin
            case ($urandom_range(2))
                0: rate = 4;
                1: rate = 30;
                default: rate = 150;
            endcase
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(rate - 1) == 0) lk = !lk;
                step(lk, $urandom_range(299) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
